// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq
//
// Runs complete SPI flash read transactions on top of a single-byte SPI
// engine. After a start request it drops CS and sends the read command and
// the 24-bit address. It then sends one 0xFF filler byte for each requested
// data byte. Bytes go to the engine one at a time, and each byte received in
// the data phase is streamed back to the requester.
//
// Optional feature macro: SPI_FLASH_FAST_READ_EN
//   defined   -> command 0x0B, then one dummy byte 0x00 after the address.
//                The byte received during the dummy byte is discarded.
//   undefined -> command 0x03, no dummy byte.
//
// Ports:
//   iSCLK       clock (single clock domain)
//   iSRST       synchronous reset, active-high
//   iStart      one-cycle start request, only honoured in IDLE
//   iAddr       24-bit flash byte address, latched on an accepted start
//   iLen        16-bit data byte count, latched on an accepted start
//   oBusy       high while a transaction is in progress
//   oRdData     most recently received data byte
//   oRdVd       one-cycle strobe, oRdData is valid
//   oDone       one-cycle strobe on return to IDLE
//   oWd         byte handed to the engine
//   oSpiEn      engine enable; low lets the engine reload oWd
//   oCsOutCtrl  flash chip select, active-low
//   oDivCke     engine SCK toggle enable
//   iRd         engine receive shift register
//   iSpiIntr    engine byte-complete pulse

module spi_flash_read_seq #(
    parameter int unsigned pDivCnt  = 1,
    parameter int unsigned pCsSetup = 2,
    parameter int unsigned pCsHold  = 2,
    parameter int unsigned pCsHigh  = 4
) (
    input  logic        iSCLK,
    input  logic        iSRST,
    input  logic        iStart,
    input  logic [23:0] iAddr,
    input  logic [15:0] iLen,
    output logic        oBusy,
    output logic [7:0]  oRdData,
    output logic        oRdVd,
    output logic        oDone,
    output logic [7:0]  oWd,
    output logic        oSpiEn,
    output logic        oCsOutCtrl,
    output logic        oDivCke,
    input  logic [7:0]  iRd,
    input  logic        iSpiIntr
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0]  cCmd    = 8'h0B;
    localparam logic [16:0] cHdrLen = 17'd5;
`else
    localparam logic [7:0]  cCmd    = 8'h03;
    localparam logic [16:0] cHdrLen = 17'd4;
`endif

    localparam logic [15:0] cSetupLast = 16'(pCsSetup - 1);
    localparam logic [15:0] cHoldLast  = 16'(pCsHold - 1);
    localparam logic [15:0] cHighLast  = 16'(pCsHigh - 1);
    localparam logic [7:0]  cDivLast   = 8'(pDivCnt);

    typedef enum logic [2:0] {IDLE, CSSU, LOAD, XFER, CSHLD, CSHI} tState;

    tState       state, stateNext;
    logic [15:0] cnt, cntNext;
    logic [16:0] idx, idxNext;
    logic [23:0] addrReg, addrNext;
    logic [15:0] lenReg, lenNext;
    logic [16:0] lastIdx;
    logic [7:0]  divCnt, divNext;
    logic        doneNext, rdVdNext;
    logic [7:0]  rdDataNext;

    // Index of the final byte of the transaction. It is 17 bits wide so that
    // the largest length plus the header does not wrap.
    assign lastIdx = {1'b0, lenReg} + cHdrLen - 17'd1;

    // Byte sent at a given position: command, address MSB first, an optional
    // dummy byte, then 0xFF fillers that clock the data out of the flash.
    function automatic logic [7:0] seqByte(input logic [16:0] i, input logic [23:0] a);
        logic [7:0] b;
        b = 8'hFF;
        if (i == 17'd0)      b = cCmd;
        else if (i == 17'd1) b = a[23:16];
        else if (i == 17'd2) b = a[15:8];
        else if (i == 17'd3) b = a[7:0];
`ifdef SPI_FLASH_FAST_READ_EN
        else if (i == 17'd4) b = 8'h00;
`endif
        return b;
    endfunction

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        idxNext    = idx;
        addrNext   = addrReg;
        lenNext    = lenReg;
        doneNext   = 1'b0;
        rdVdNext   = 1'b0;
        rdDataNext = oRdData;
        case (state)
            IDLE: begin
                if (iStart) begin
                    if (iLen != 16'd0) begin
                        addrNext  = iAddr;
                        lenNext   = iLen;
                        idxNext   = 17'd0;
                        cntNext   = 16'd0;
                        stateNext = CSSU;
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end
            CSSU: begin
                if (cnt == cSetupLast) begin
                    cntNext   = 16'd0;
                    stateNext = LOAD;
                end else begin
                    cntNext = cnt + 16'd1;
                end
            end
            LOAD: stateNext = XFER;
            XFER: begin
                if (iSpiIntr) begin
                    // Bytes received during the header are don't-care echoes.
                    if (idx >= cHdrLen) begin
                        rdVdNext   = 1'b1;
                        rdDataNext = iRd;
                    end
                    idxNext = idx + 17'd1;
                    if (idx == lastIdx) begin
                        cntNext   = 16'd0;
                        stateNext = CSHLD;
                    end else begin
                        stateNext = LOAD;
                    end
                end
            end
            CSHLD: begin
                if (cnt == cHoldLast) begin
                    cntNext   = 16'd0;
                    stateNext = CSHI;
                end else begin
                    cntNext = cnt + 16'd1;
                end
            end
            CSHI: begin
                if (cnt == cHighLast) begin
                    cntNext   = 16'd0;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The divider restarts on every byte. It only advances once the
    // registered enable is already high, so count 0 lines up with the first
    // XFER cycle.
    always_comb begin
        divNext = 8'd0;
        if (stateNext == XFER && oSpiEn) begin
            divNext = (divCnt == cDivLast) ? 8'd0 : divCnt + 8'd1;
        end
    end

    // Every output is registered from the next-state decode, so outputs
    // change on the same edge as the state they belong to.
    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            idx        <= 17'd0;
            addrReg    <= 24'd0;
            lenReg     <= 16'd0;
            divCnt     <= 8'd0;
            oBusy      <= 1'b0;
            oRdData    <= 8'h00;
            oRdVd      <= 1'b0;
            oDone      <= 1'b0;
            oWd        <= 8'h00;
            oSpiEn     <= 1'b0;
            oCsOutCtrl <= 1'b1;
            oDivCke    <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            idx        <= idxNext;
            addrReg    <= addrNext;
            lenReg     <= lenNext;
            divCnt     <= divNext;
            oBusy      <= (stateNext != IDLE);
            oRdData    <= rdDataNext;
            oRdVd      <= rdVdNext;
            oDone      <= doneNext;
            if (stateNext == LOAD) begin
                oWd <= seqByte(idxNext, addrNext);
            end
            oSpiEn     <= (stateNext == XFER);
            oCsOutCtrl <= !(stateNext inside {CSSU, LOAD, XFER, CSHLD});
            oDivCke    <= (stateNext == XFER) && (divNext == cDivLast);
        end
    end

endmodule

// File: doc/spi_flash_read_seq.md
# spi_flash_read_seq

Sequencer that drives the single-byte SPI flash engine to perform complete flash read transactions. On a start request it holds CS low and issues the read command, a 24-bit address and N data bytes, feeding the engine one byte at a time. It generates the SCK divider enable and streams received bytes to the requester. It sits between the SPI block CSR/DMA logic (requester side) and the byte engine (engine side).

## Interface
- pDivCnt, 1: `oDivCke` fires once every pDivCnt+1 cycles; SCK = iSCLK/(2·(pDivCnt+1)); range 0..255
- pCsSetup, 2: iSCLK cycles from CS low to first byte load; ≥1
- pCsHold, 2: iSCLK cycles from last byte interrupt to CS high; ≥1
- pCsHigh, 4: minimum CS-high cycles before the next transaction may start; ≥1
- iSCLK  in  1  clock; one clock domain
- iSRST  in  1  synchronous reset, active-high
- iStart  in  1  one-cycle start request; sampled only in IDLE
- iAddr  in  24  flash byte address; latched on accepted iStart
- iLen  in  16  data byte count; latched on accepted iStart
- oBusy  out  1  high from the cycle after accepted iStart until return to IDLE
- oRdData  out  8  received data byte
- oRdVd  out  1  one-cycle strobe; oRdData valid
- oDone  out  1  one-cycle strobe on return to IDLE
- oWd  out  8  byte to engine
- oSpiEn  out  1  engine enable; low reloads oWd
- oCsOutCtrl  out  1  flash CS, active-low
- oDivCke  out  1  engine SCK toggle enable
- iRd  in  8  engine receive shift register
- iSpiIntr  in  1  engine one-cycle byte-complete pulse

## Operation
- States: IDLE, CSSU, LOAD, XFER, CSHLD, CSHI.
- IDLE: oCsOutCtrl=1, oSpiEn=0. iStart=1 with iLen≠0 → latch iAddr/iLen, byte index=0, → CSSU. iStart=1 with iLen=0 → no CS activity, oDone pulses next cycle. iStart outside IDLE is ignored.
- CSSU: oCsOutCtrl=0; count pCsSetup cycles → LOAD.
- LOAD: exactly one cycle; oSpiEn=0, oWd = byte[index] → XFER.
- XFER: oSpiEn=1; divider counter runs. On iSpiIntr: if index is in the data phase, oRdData←iRd and oRdVd=1 in the same edge; index+1; if last byte → CSHLD, else → LOAD.
- Byte sequence: 0x03, iAddr[23:16], iAddr[15:8], iAddr[7:0], then iLen bytes of 0xFF. Total bytes = 4 + iLen; index width is 17 bits, so no wrap for iLen=0xFFFF.
- CSHLD: oCsOutCtrl=0, oSpiEn=0; count pCsHold cycles → CSHI.
- CSHI: oCsOutCtrl=1; count pCsHigh cycles → IDLE with oDone=1 for one cycle.
- Divider: counter cleared whenever oSpiEn=0. While oSpiEn=1 it counts 0..pDivCnt, and oDivCke=1 on the cycle count==pDivCnt.
- Reset (any state, including mid-byte): next edge → IDLE. Reset values: oCsOutCtrl=1; oSpiEn=0; oDivCke=0; oBusy=0; oRdVd=0; oDone=0; oRdData=0x00; oWd=0x00. No oDone is issued for an aborted transaction.

## Timing
- All outputs are registered.
- Accepted iStart at edge 0 → oBusy=1 and oCsOutCtrl=0 after edge 1.
- First LOAD occurs pCsSetup cycles after CS goes low.
- Per-byte cost: 1 LOAD cycle + 16·(pDivCnt+1) XFER cycles, nominal. The engine interrupt may add a fixed engine-dependent cycle. The bench checks byte order, values and strobes, not exact byte period.
- oRdVd is asserted on the edge after iSpiIntr is sampled high, coincident with the oRdData update.
- oDone coincides with oBusy falling.
- Back-to-back transactions: iStart is accepted in the cycle oDone is high. Minimum CS-high time is pCsHigh+1 cycles.

## Configuration
- SPI_FLASH_FAST_READ_EN defined:
  - Command byte is 0x0B.
  - One dummy byte 0x00 is inserted after the address; total bytes = 5 + iLen.
  - The dummy byte's received value is discarded (no oRdVd).
- SPI_FLASH_FAST_READ_EN undefined: command 0x03, no dummy byte.

## Test plan
- pDivCnt=1, read iAddr=0x012345, iLen=4; flash model returns A5 5A 00 FF → MOSI bytes 03 01 23 45 FF FF FF FF. oRdVd fires 4 times with A5, 5A, 00, FF. CS stays low across all 8 bytes. One oDone.
- iStart with iLen=0 → oCsOutCtrl stays 1, oSpiEn stays 0, oDone pulses one cycle later, no oRdVd.
- iStart pulsed during XFER of a running read → ignored. Only one oDone; byte count unchanged.
- iSRST asserted during the 2nd data byte → next cycle oCsOutCtrl=1, oSpiEn=0, oBusy=0. No oDone. A new read after reset completes correctly.
- Back-to-back: iStart in the oDone cycle → second transaction starts. CS high for exactly pCsHigh+1 cycles between transactions.
- With SPI_FLASH_FAST_READ_EN, iAddr=0x000010, iLen=2 → MOSI 0B 00 00 10 00 FF FF. Exactly 2 oRdVd strobes.
